// File: rtl/corelet_seq.sv
// Self-sequencing corelet: weight-stationary MAC array, tagged output FIFO and a
// sequencer that runs kij_len x nij_len outputs of one conv layer from a single start pulse.
module corelet_seq #(
  parameter int bw       = 4,
  parameter int psum_bw  = 16,
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int KIJ_MAX  = 9,
  parameter int NIJ_MAX  = 16,
  parameter int OF_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           mode_2bit,
  input  logic [$clog2(KIJ_MAX+1)-1:0]   kij_len,
  input  logic [$clog2(NIJ_MAX+1)-1:0]   nij_len,
  input  logic [row*bw-1:0]              in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [col*psum_bw-1:0]         out_data,
  output logic [$clog2(KIJ_MAX)-1:0]     out_kij,
  output logic [$clog2(NIJ_MAX)-1:0]     out_nij,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int KW   = $clog2(KIJ_MAX + 1);
  localparam int NW   = $clog2(NIJ_MAX + 1);
  localparam int KTW  = $clog2(KIJ_MAX);
  localparam int NTW  = $clog2(NIJ_MAX);
  localparam int CW   = $clog2(OF_DEPTH + 1);
  localparam int AW   = $clog2(OF_DEPTH);
  localparam int CIW  = $clog2(col);
  localparam int CNTW = $clog2(row + col + NIJ_MAX + 1);
  localparam int DW   = col * psum_bw;
  localparam int EW   = DW + NTW + KTW;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_SETTLE, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_n;

  logic [KW-1:0]   kij_r, kij_len_r;
  logic [NW-1:0]   nij_len_r, wr_cnt;
  logic [CNTW-1:0] cnt;
  logic            mode_r, err_r, arr_clr;
  logic [1:0]      inst_w;
  logic            len_ok, xfer, settled;

  logic [row*bw-1:0]         w_mem [col];
  logic [row*bw-1:0]         act_r;
  logic                      act_v, psum_v;
  logic [DW-1:0]             psum_r, dot;
  logic signed [psum_bw-1:0] acc, wv, av;
  logic [bw-1:0]             wsl, asl;

  logic [EW-1:0] fifo_mem [OF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fcnt;
  logic          fifo_wr, fifo_rd;
  logic [EW-1:0] head;

  assign len_ok = (kij_len != '0) && (kij_len <= KW'(KIJ_MAX)) &&
                  (nij_len != '0) && (nij_len <= NW'(NIJ_MAX));
  assign in_ready = !abort && (state == S_LOAD_W || state == S_EXEC);
  assign xfer     = in_valid && in_ready;
  // EXEC may only begin once the whole kij's results are guaranteed a FIFO slot
  assign settled  = (cnt == CNTW'(row + col - 1)) &&
                    (32'(CW'(OF_DEPTH) - fcnt) >= 32'(nij_len_r));
  assign busy     = (state != S_IDLE);
  assign err      = err_r;

  always_comb begin
    state_n = state;
    inst_w  = 2'b00;
    done    = 1'b0;
    unique case (state)
      S_IDLE:   if (start && len_ok) state_n = S_LOAD_W;
      S_LOAD_W: if (xfer) begin
                  inst_w = 2'b01;
                  if (cnt == CNTW'(col - 1)) state_n = S_SETTLE;
                end
      S_SETTLE: if (settled) state_n = S_EXEC;
      S_EXEC:   if (xfer) begin
                  inst_w = 2'b10;
                  if (cnt == CNTW'(nij_len_r) - CNTW'(1)) state_n = S_DRAIN;
                end
      S_DRAIN:  if (wr_cnt == nij_len_r)
                  state_n = (kij_r == kij_len_r - KW'(1)) ? S_DONE : S_LOAD_W;
      S_DONE:   if (fcnt == '0) begin
                  done    = 1'b1;
                  state_n = S_IDLE;
                end
      default:  state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      kij_r     <= '0;
      kij_len_r <= '0;
      nij_len_r <= '0;
      mode_r    <= 1'b0;
      err_r     <= 1'b0;
      cnt       <= '0;
      wr_cnt    <= '0;
      arr_clr   <= 1'b0;
    end else begin
      state   <= state_n;
      arr_clr <= (state_n == S_LOAD_W) && (state != S_LOAD_W);
      if (state == S_IDLE && start) begin
        if (len_ok) begin
          kij_len_r <= kij_len;
          nij_len_r <= nij_len;
          mode_r    <= mode_2bit;
          err_r     <= 1'b0;
        end else begin
          err_r <= 1'b1;
        end
      end
      // one counter serves weight beats, settle cycles and activation beats
      if (state_n != state)
        cnt <= '0;
      else if (xfer || (state == S_SETTLE && cnt != CNTW'(row + col - 1)))
        cnt <= cnt + CNTW'(1);
      if (state == S_IDLE)
        kij_r <= '0;
      else if (state == S_DRAIN && state_n == S_LOAD_W)
        kij_r <= kij_r + KW'(1);
      if (state == S_LOAD_W || abort)
        wr_cnt <= '0;
      else if (fifo_wr)
        wr_cnt <= wr_cnt + NW'(1);
    end
  end

  // MAC array: beat j of LOAD_W holds the row weights of column j
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < col; c++) w_mem[c] <= '0;
      act_r  <= '0;
      act_v  <= 1'b0;
      psum_r <= '0;
      psum_v <= 1'b0;
    end else begin
      if (arr_clr)
        for (int unsigned c = 0; c < col; c++) w_mem[c] <= '0;
      if (inst_w[0]) w_mem[cnt[CIW-1:0]] <= in_data;
      if (inst_w[1]) act_r <= in_data;
      if (act_v) psum_r <= dot;
      act_v  <= inst_w[1] && !arr_clr && !abort;
      psum_v <= act_v && !arr_clr && !abort;
    end
  end

  // signed weights x unsigned activations; 2-bit mode sums the two packed 2-bit activations
  always_comb begin
    dot = '0;
    acc = '0;
    wv  = '0;
    av  = '0;
    wsl = '0;
    asl = '0;
    for (int unsigned c = 0; c < col; c++) begin
      acc = '0;
      for (int unsigned r = 0; r < row; r++) begin
        wsl = w_mem[c][r*bw +: bw];
        asl = act_r[r*bw +: bw];
        wv  = psum_bw'(signed'(wsl));
        av  = mode_r ? psum_bw'(asl[bw/2-1:0]) + psum_bw'(asl[bw-1:bw/2]) : psum_bw'(asl);
        acc = acc + wv * av;
      end
      dot[c*psum_bw +: psum_bw] = acc;
    end
  end

  assign fifo_rd   = out_valid && out_ready;
  assign fifo_wr   = psum_v && !abort && ((fcnt != CW'(OF_DEPTH)) || fifo_rd);
  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (fcnt != '0);
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_nij   = out_valid ? head[DW +: NTW] : '0;
  assign out_kij   = out_valid ? head[DW+NTW +: KTW] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= (wr_ptr == AW'(OF_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= (rd_ptr == AW'(OF_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (fifo_wr && !fifo_rd)
        fcnt <= fcnt + CW'(1);
      else if (fifo_rd && !fifo_wr)
        fcnt <= fcnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= {kij_r[KTW-1:0], wr_cnt[NTW-1:0], psum_r};
  end

endmodule

// File: tb/tb_corelet_seq.sv
// Directed bench for corelet_seq: fixed-pattern runs with hand-computed psums, patterned
// multi-kij runs against a dot-product model, back-pressure, abort, illegal start, async reset.
module tb_corelet_seq;
  localparam int LIMIT = 1000;

  logic         clk = 1'b0;
  logic         reset, start, abort, mode_2bit, in_valid, in_ready;
  logic         out_valid, out_ready, busy, done, err;
  logic [3:0]   kij_len;
  logic [4:0]   nij_len;
  logic [31:0]  in_data;
  logic [127:0] out_data;
  logic [3:0]   out_kij, out_nij;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int seed     = 0;
  int fixed_w  = -1;
  int fixed_a  = -1;
  bit mode_m   = 1'b0;
  bit stuck    = 1'b0;
  int d0;

  corelet_seq #(.bw(4), .psum_bw(16), .row(8), .col(8), .KIJ_MAX(9), .NIJ_MAX(16), .OF_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode_2bit(mode_2bit),
    .kij_len(kij_len), .nij_len(nij_len), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_kij(out_kij), .out_nij(out_nij),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  function automatic logic [3:0] wgt(int k, int c, int r);
    if (fixed_w >= 0) return 4'(fixed_w);
    return 4'((k * 7 + c * 3 + r * 5 + c * r + seed) % 16);
  endfunction

  function automatic logic [3:0] act(int k, int n, int r);
    if (fixed_a >= 0) return 4'(fixed_a);
    return 4'((k * 5 + n * 9 + r * 3 + k * n + seed * 3) % 16);
  endfunction

  function automatic logic [31:0] wvec(int k, int c);
    logic [31:0] v;
    for (int r = 0; r < 8; r++) v[r*4 +: 4] = wgt(k, c, r);
    return v;
  endfunction

  function automatic logic [31:0] avec(int k, int n);
    logic [31:0] v;
    for (int r = 0; r < 8; r++) v[r*4 +: 4] = act(k, n, r);
    return v;
  endfunction

  function automatic logic [127:0] expv(int k, int n);
    logic [127:0] v;
    int s, w, a;
    v = '0;
    for (int c = 0; c < 8; c++) begin
      s = 0;
      for (int r = 0; r < 8; r++) begin
        w = int'(wgt(k, c, r));
        if (w > 7) w -= 16;
        a = int'(act(k, n, r));
        if (mode_m) a = (a % 4) + (a / 4);
        s += w * a;
      end
      v[c*16 +: 16] = 16'(s);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    stuck = 1'b1;
    $error("FAIL %s: observed no event expected one within %0d cycles", tag, LIMIT);
  endtask

  task automatic send(input logic [31:0] v);
    int g;
    if (stuck) return;
    g = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && g < LIMIT) begin @(negedge clk); g++; end
    if (g >= LIMIT) begin in_valid = 1'b0; timeout("in_ready"); return; end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic feed(input int kl, input int nl, input int ak, input int an);
    for (int k = 0; k < kl; k++) begin
      for (int c = 0; c < 8; c++) send(wvec(k, c));
      for (int n = 0; n < nl; n++) begin
        if (k == ak && n == an) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_busy", busy, 1'b0);
          chk("abort_in_ready", in_ready, 1'b0);
          chk("abort_out_valid", out_valid, 1'b0);
          return;
        end
        send(avec(k, n));
      end
    end
  endtask

  task automatic consume(input int nl, input int total);
    int g;
    for (int i = 0; i < total; i++) begin
      if (stuck) return;
      g = 0;
      while (!out_valid && g < LIMIT) begin @(negedge clk); g++; end
      if (g >= LIMIT) begin timeout("out_valid"); return; end
      chk("out_data", out_data, expv(i / nl, i % nl));
      chk("out_tag", {out_kij, out_nij}, {4'(i / nl), 4'(i % nl)});
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < LIMIT) begin @(negedge clk); g++; end
    if (g >= LIMIT) timeout("busy_fall");
  endtask

  task automatic do_start(input int kl, input int nl, input bit m);
    kij_len   = 4'(kl);
    nij_len   = 5'(nl);
    mode_2bit = m;
    mode_m    = m;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int kl, input int nl, input bit m);
    int dn;
    dn = done_cnt;
    out_ready = 1'b1;
    do_start(kl, nl, m);
    chk("run_busy", busy, 1'b1);
    fork
      feed(kl, nl, -1, -1);
      consume(nl, kl * nl);
    join
    wait_idle();
    @(negedge clk);
    chk("run_done_once", done_cnt - dn, 1);
  endtask

  task automatic single(input int fw, input int fa, input bit m, input logic [15:0] e);
    int g, dn;
    fixed_w   = fw;
    fixed_a   = fa;
    out_ready = 1'b0;
    dn        = done_cnt;
    do_start(1, 1, m);
    feed(1, 1, -1, -1);
    g = 0;
    while (!out_valid && g < LIMIT) begin @(negedge clk); g++; end
    if (g >= LIMIT) timeout("single_valid");
    chk("single_data", out_data, {8{e}});
    chk("single_tag", {out_kij, out_nij}, 8'h00);
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_pop", out_valid, 1'b0);
    wait_idle();
    @(negedge clk);
    chk("single_done", done_cnt - dn, 1);
    fixed_w = -1;
    fixed_a = -1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode_2bit = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; kij_len = '0; nij_len = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_out_data", out_data, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // T1 plus fixed-pattern variants: 8 rows x (1*1)=8, 8 x 1*(3+3)=48, 8 x (-1*15)=-120
    single(1, 1, 1'b0, 16'h0008);
    single(1, 15, 1'b1, 16'h0030);
    single(15, 15, 1'b0, 16'hFF88);

    // T2: full-size run, then a short 2-bit-mode run
    seed = 1;
    run(9, 16, 1'b0);
    seed = 2;
    run(3, 5, 1'b1);

    // T3: consumer stalled, FIFO fills and the second kij must wait
    seed = 3;
    out_ready = 1'b0;
    d0 = done_cnt;
    do_start(2, 16, 1'b0);
    fork
      feed(2, 16, -1, -1);
      begin
        repeat (120) @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_busy", busy, 1'b1);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_head_data", out_data, expv(0, 0));
        chk("bp_head_tag", {out_kij, out_nij}, 8'h00);
        out_ready = 1'b1;
        consume(16, 32);
      end
    join
    wait_idle();
    @(negedge clk);
    chk("bp_done_once", done_cnt - d0, 1);

    // T4: abort during EXEC of kij 3, then a clean run
    seed = 4;
    out_ready = 1'b1;
    d0 = done_cnt;
    do_start(4, 4, 1'b0);
    fork
      feed(4, 4, 3, 2);
      consume(4, 12);
    join
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 1'b0);
    chk("abort_empty", out_valid, 1'b0);
    seed = 6;
    run(1, 3, 1'b0);

    // T5: illegal lengths set err, a legal start clears it
    do_start(0, 4, 1'b0);
    chk("err_kij0", err, 1'b1);
    chk("err_kij0_busy", busy, 1'b0);
    do_start(1, 17, 1'b0);
    chk("err_nij17", err, 1'b1);
    chk("err_nij17_busy", busy, 1'b0);
    seed = 7;
    run(2, 3, 1'b0);
    chk("err_cleared", err, 1'b0);

    // T6: asynchronous reset while in DRAIN
    seed = 5;
    out_ready = 1'b0;
    do_start(1, 4, 1'b0);
    for (int c = 0; c < 8; c++) send(wvec(0, c));
    for (int n = 0; n < 4; n++) send(avec(0, n));
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, '0);
    chk("arst_tag", {out_kij, out_nij}, 8'h00);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    seed = 8;
    run(1, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
